// File: rtl/log_offset_lut_arb_pkg.sv
// Shared types for the log-offset LUT arbiter slice.
// Widths of the shift-offset index and the LUT data word.
package log_offset_pkg;

  localparam int OFF_W = 4;
  localparam int DAT_W = 24;

  typedef logic [OFF_W-1:0] shift_off_t;
  typedef logic [DAT_W-1:0] log_off_t;

endpackage

// File: rtl/log_offset_lut_arb_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first request at or after ptr, wrapping to 0.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic [IDX_W:0] pos;
  logic           found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, ptr} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(NUM_REQ))
        pos = pos - (IDX_W+1)'(NUM_REQ);
      if (en && !found && req[pos[IDX_W-1:0]]) begin
        gnt[pos[IDX_W-1:0]] = 1'b1;
        gnt_idx             = pos[IDX_W-1:0];
        found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/log_offset_lut_arb.sv
// Round-robin scheduler sharing one registered log-offset LUT.
// Tags ride a shift pipe so each result returns to its requester.
module log_offset_lut_arb
  import log_offset_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LUT_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*OFF_W-1:0] req_offset,
  output logic [NUM_REQ-1:0]       req_ready,
  output shift_off_t               lut_shift_offset,
  input  log_off_t                 lut_log_offset,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output log_off_t                 rsp_data,
  output logic                     busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } lut_tag_t;

  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               arb_en;
  logic               accept;
  lut_tag_t           tag_q [LUT_LAT+1];
  lut_tag_t           rsp_tag;
  log_off_t           rsp_hold_q;

  // Grants are suppressed while reset is held so req_ready reads 0.
  assign arb_en = !stall && rst_n;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req    (req_valid),
    .en     (arb_en),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;
  assign rsp_tag   = tag_q[LUT_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q            <= '0;
      lut_shift_offset <= '0;
    end else if (accept) begin
      ptr_q <= (gnt_idx == IDX_W'(NUM_REQ-1)) ?
               '0 : gnt_idx + IDX_W'(1);
      lut_shift_offset <=
        req_offset[int'(gnt_idx)*OFF_W +: OFF_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= LUT_LAT; k++)
        tag_q[k] <= '0;
    end else begin
      tag_q[0].vld <= accept;
      tag_q[0].idx <= gnt_idx;
      for (int k = 1; k <= LUT_LAT; k++)
        tag_q[k] <= tag_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rsp_hold_q <= '0;
    else if (rsp_tag.vld)
      rsp_hold_q <= lut_log_offset;
  end

  // Data is live in the response cycle and held afterwards.
  assign rsp_data = rsp_tag.vld ? lut_log_offset : rsp_hold_q;

  always_comb begin
    rsp_valid = '0;
    if (rsp_tag.vld)
      rsp_valid[rsp_tag.idx] = 1'b1;
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k <= LUT_LAT; k++)
      busy = busy | tag_q[k].vld;
  end

endmodule

// File: tb/tb_log_offset_lut_arb.sv
// Directed bench for log_offset_lut_arb.
// Drives just after posedge, samples on negedge.
module tb_log_offset_lut_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [3:0]  req_valid;
  logic [15:0] req_offset;
  logic [3:0]  req_ready;
  logic [3:0]  lut_shift_offset;
  logic [23:0] lut_log_offset;
  logic [3:0]  rsp_valid;
  logic [23:0] rsp_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  log_offset_lut_arb #(
    .NUM_REQ(4),
    .LUT_LAT(1)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .req_valid       (req_valid),
    .req_offset      (req_offset),
    .req_ready       (req_ready),
    .lut_shift_offset(lut_shift_offset),
    .lut_log_offset  (lut_log_offset),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .busy            (busy)
  );

  function automatic logic [23:0] lut_fn(input logic [3:0] o);
    case (o)
      4'h0, 4'h1: lut_fn = 24'h000000;
      4'h2:       lut_fn = 24'hA98A98;
      4'h3:       lut_fn = 24'hF44F44;
      4'hE, 4'hF: lut_fn = 24'hFFFFFF;
      default:    lut_fn = {6{o}};
    endcase
  endfunction

  // Registered LUT: one cycle from index to data.
  always @(posedge clk) lut_log_offset <= lut_fn(lut_shift_offset);

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    stall = 1'b0;
    req_valid = 4'h0;
    req_offset = 16'h0;
    #2;
    req_valid = 4'hF;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'h0) begin
      errors++;
      $display("FAIL rst_ready: got %b need 0000", req_ready);
    end
    checks++;
    if (lut_shift_offset !== 4'h0) begin
      errors++;
      $display("FAIL rst_off: got %h need 0", lut_shift_offset);
    end
    checks++;
    if (rsp_valid !== 4'h0) begin
      errors++;
      $display("FAIL rst_rspv: got %b need 0000", rsp_valid);
    end
    checks++;
    if (rsp_data !== 24'h0) begin
      errors++;
      $display("FAIL rst_data: got %h need 0", rsp_data);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy: got %b need 0", busy);
    end
    req_valid = 4'h0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    req_valid = 4'b0001;
    req_offset = 16'h0002;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL t1_ready: got %b need 0001", req_ready);
    end
    step();
    req_valid = 4'h0;
    @(negedge clk);
    checks++;
    if (lut_shift_offset !== 4'h2) begin
      errors++;
      $display("FAIL t1_off: got %h need 2", lut_shift_offset);
    end
    checks++;
    if (rsp_valid !== 4'h0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL t1_mid: got rsp %b busy %b need 0000 1",
               rsp_valid, busy);
    end
    step();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0001) begin
      errors++;
      $display("FAIL t1_rspv: got %b need 0001", rsp_valid);
    end
    checks++;
    if (rsp_data !== 24'hA98A98) begin
      errors++;
      $display("FAIL t1_data: got %h need a98a98", rsp_data);
    end
    step();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t1_end: got rsp %b busy %b need 0000 0",
               rsp_valid, busy);
    end
    checks++;
    if (rsp_data !== 24'hA98A98) begin
      errors++;
      $display("FAIL t1_hold: got %h need a98a98", rsp_data);
    end
    step();
  endtask

  task automatic test_round_robin;
    logic [23:0] rr_dat [4];
    logic [3:0]  exp;
    rr_dat = '{24'hA98A98, 24'hF44F44, 24'h444444, 24'h555555};
    do_reset();
    req_offset = 16'h5432;
    for (int k = 0; k < 10; k++) begin
      req_valid = (k < 8) ? 4'hF : 4'h0;
      @(negedge clk);
      if (k < 8) begin
        exp = 4'b0001 << (k % 4);
        checks++;
        if (req_ready !== exp) begin
          errors++;
          $display("FAIL t2_ready[%0d]: got %b need %b",
                   k, req_ready, exp);
        end
      end
      if (k >= 2) begin
        exp = 4'b0001 << ((k - 2) % 4);
        checks++;
        if (rsp_valid !== exp) begin
          errors++;
          $display("FAIL t2_rspv[%0d]: got %b need %b",
                   k, rsp_valid, exp);
        end
        checks++;
        if (rsp_data !== rr_dat[(k-2)%4]) begin
          errors++;
          $display("FAIL t2_data[%0d]: got %h need %h",
                   k, rsp_data, rr_dat[(k-2)%4]);
        end
      end
      step();
    end
  endtask

  task automatic test_wrap_skip;
    logic [3:0]  exp_g [5];
    logic [23:0] exp_d [5];
    exp_g = '{4'b1000, 4'b0010, 4'b1000, 4'b0000, 4'b0000};
    exp_d = '{24'h0, 24'h0, 24'h555555, 24'hF44F44, 24'h555555};
    do_reset();
    req_offset = 16'h5030;
    req_valid = 4'b0010;
    step();
    req_valid = 4'h0;
    step();
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      req_valid = (k < 3) ? 4'b1010 : 4'b0000;
      @(negedge clk);
      checks++;
      if (req_ready !== exp_g[k]) begin
        errors++;
        $display("FAIL t3_ready[%0d]: got %b need %b",
                 k, req_ready, exp_g[k]);
      end
      if (k >= 2) begin
        checks++;
        if (rsp_valid !== exp_g[k-2] ||
            rsp_data !== exp_d[k]) begin
          errors++;
          $display("FAIL t3_rsp[%0d]: got %b/%h need %b/%h",
                   k, rsp_valid, rsp_data, exp_g[k-2], exp_d[k]);
        end
      end
      step();
    end
  endtask

  task automatic test_stall;
    logic [3:0]  exp_g [6];
    logic [3:0]  exp_r [6];
    logic        exp_b [6];
    logic [23:0] exp_d [6];
    exp_g = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
    exp_r = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b0000};
    exp_b = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_d = '{24'h0, 24'h0, 24'h666666, 24'h777777,
              24'h777777, 24'h777777};
    do_reset();
    req_offset = 16'h0076;
    for (int k = 0; k < 6; k++) begin
      stall = (k >= 2 && k <= 4);
      req_valid = (k < 5) ? 4'b0011 : 4'b1111;
      @(negedge clk);
      checks++;
      if (req_ready !== exp_g[k]) begin
        errors++;
        $display("FAIL t4_ready[%0d]: got %b need %b",
                 k, req_ready, exp_g[k]);
      end
      checks++;
      if (rsp_valid !== exp_r[k] || busy !== exp_b[k]) begin
        errors++;
        $display("FAIL t4_rsp[%0d]: got %b busy %b need %b busy %b",
                 k, rsp_valid, busy, exp_r[k], exp_b[k]);
      end
      if (k >= 2) begin
        checks++;
        if (rsp_data !== exp_d[k]) begin
          errors++;
          $display("FAIL t4_data[%0d]: got %h need %h",
                   k, rsp_data, exp_d[k]);
        end
      end
      step();
    end
    req_valid = 4'h0;
    stall = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic test_boundary;
    logic [3:0]  offs [3];
    logic [3:0]  exp_o [6];
    logic [23:0] exp_d [6];
    offs  = '{4'h0, 4'hE, 4'hF};
    exp_o = '{4'h0, 4'h0, 4'hE, 4'hF, 4'hF, 4'hF};
    exp_d = '{24'h0, 24'h0, 24'h000000, 24'hFFFFFF,
              24'hFFFFFF, 24'hFFFFFF};
    do_reset();
    req_offset = 16'h0;
    for (int k = 0; k < 6; k++) begin
      req_valid = (k < 3) ? 4'b0100 : 4'b0000;
      if (k < 3) req_offset[11:8] = offs[k];
      @(negedge clk);
      if (k < 3) begin
        checks++;
        if (req_ready !== 4'b0100) begin
          errors++;
          $display("FAIL t5_ready[%0d]: got %b need 0100",
                   k, req_ready);
        end
      end
      checks++;
      if (lut_shift_offset !== exp_o[k]) begin
        errors++;
        $display("FAIL t5_off[%0d]: got %h need %h",
                 k, lut_shift_offset, exp_o[k]);
      end
      if (k >= 2 && k < 5) begin
        checks++;
        if (rsp_valid !== 4'b0100 || rsp_data !== exp_d[k]) begin
          errors++;
          $display("FAIL t5_rsp[%0d]: got %b/%h need 0100/%h",
                   k, rsp_valid, rsp_data, exp_d[k]);
        end
      end
      if (k == 5) begin
        checks++;
        if (rsp_valid !== 4'h0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL t5_end: got %b busy %b need 0000 0",
                   rsp_valid, busy);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid_flight;
    req_valid = 4'b0010;
    req_offset = 16'h0030;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL t6_ready: got %b need 0010", req_ready);
    end
    step();
    rst_n = 1'b0;
    req_valid = 4'hF;
    #1;
    checks++;
    if (req_ready !== 4'h0 || rsp_valid !== 4'h0 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL t6_rst: got rdy %b rsp %b busy %b need 0",
               req_ready, rsp_valid, busy);
    end
    checks++;
    if (lut_shift_offset !== 4'h0 || rsp_data !== 24'h0) begin
      errors++;
      $display("FAIL t6_rst_dat: got %h/%h need 0/0",
               lut_shift_offset, rsp_data);
    end
    step();
    step();
    rst_n = 1'b1;
    req_valid = 4'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 4'h0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL t6_drop[%0d]: got %b busy %b need 0000 0",
                 k, rsp_valid, busy);
      end
      step();
    end
    req_valid = 4'hF;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL t6_first: got %b need 0001", req_ready);
    end
    step();
    req_valid = 4'h0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_skip();
    test_stall();
    test_boundary();
    test_reset_mid_flight();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
